// File: rtl/dff_share_pkg.sv
// Shared types and constants for the shared-register round-robin arbiter.
// Latency: none; package holds only types, constants and width helpers.
// Backpressure: not applicable.
package dff_share_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_NREQ   = 4;
    localparam int DEF_TENURE = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Width of a requester index; never zero so a 1-bit bus still exists.
    function automatic int owner_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of the tenure counter, which must be able to hold TENURE itself.
    function automatic int cnt_w(input int t);
        return $clog2(t + 1);
    endfunction

    localparam int DEF_OWNER_W = owner_w(DEF_NREQ);
    localparam int DEF_CNT_W   = cnt_w(DEF_TENURE);

endpackage

// File: rtl/dff_share_arb_if.sv
// Requester/consumer bundle for the shared-register arbiter.
// Latency: none; plain wires.
// Backpressure: level req held by producers; gnt tells each producer when its din is taken.
interface dff_share_arb_if import dff_share_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ
);
    localparam int OW = owner_w(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] din;
    logic [NREQ-1:0]       gnt;
    logic [OW-1:0]         owner;
    logic [WIDTH-1:0]      q;
    logic [WIDTH-1:0]      qn;
    logic                  valid;

    modport master (
        output req, din,
        input  gnt, owner, q, qn, valid
    );

    modport slave (
        input  req, din,
        output gnt, owner, q, qn, valid
    );

endinterface

// File: rtl/dff_rr_pick.sv
// Rotating-priority picker: first set req bit at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; any=0 means no requester is asking.
module dff_rr_pick import dff_share_pkg::*; #(
    parameter int NREQ = DEF_NREQ,
    localparam int OW  = owner_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [OW-1:0]   ptr,
    output logic            any,
    output logic [OW-1:0]   winner
);

    // Walk the ring starting at ptr and latch the first requester seen.
    always_comb begin
        int idx;
        any    = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = OW'(idx);
            end
        end
    end

endmodule

// File: rtl/dff_share_arb.sv
// Round-robin arbiter sharing one WIDTH-bit D register among NREQ requesters.
// Latency: req->gnt 1 cycle from idle; din[owner]->q 1 cycle; qn is ~q with no delay.
// Backpressure: non-owners wait on level req; owner yields after TENURE cycles if others wait.
module dff_share_arb import dff_share_pkg::*; #(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NREQ   = DEF_NREQ,
    parameter int TENURE = DEF_TENURE
) (
    input logic             clk,
    input logic             rst,
    dff_share_arb_if.slave  bus
);

    localparam int OW = owner_w(NREQ);
    localparam int CW = cnt_w(TENURE);

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q;
    logic             valid_q;

    logic [NREQ-1:0] pick_req;
    logic            pick_any;
    logic [OW-1:0]   pick_win;
    logic            own_req;
    logic            load;
    logic [WIDTH-1:0] load_dat;

    // While busy the current owner is masked out, so "any" means "someone else waits".
    assign pick_req = (state_q == BUSY) ? (bus.req & ~gnt_q) : bus.req;
    assign own_req  = |(bus.req & gnt_q);
    assign load     = (state_q == BUSY) && own_req;

    dff_rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (pick_req),
        .ptr    (ptr_q),
        .any    (pick_any),
        .winner (pick_win)
    );

    // Next-state logic: grant, handover on release or tenure expiry, counter saturation.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = BUSY;
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << pick_win;
                    owner_d = pick_win;
                    ptr_d   = (int'(pick_win) == NREQ-1) ? '0 : pick_win + OW'(1);
                    cnt_d   = CW'(1);
                end
            end
            BUSY: begin
                if ((!own_req || (cnt_q == CW'(TENURE))) && pick_any) begin
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << pick_win;
                    owner_d = pick_win;
                    ptr_d   = (int'(pick_win) == NREQ-1) ? '0 : pick_win + OW'(1);
                    cnt_d   = CW'(1);
                end else if (!own_req) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end else if (cnt_q != CW'(TENURE)) begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Arbitration state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Mux the granted requester's data; gnt is one-hot so at most one term is live.
    always_comb begin
        load_dat = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_q[k]) load_dat = bus.din[k*WIDTH +: WIDTH];
        end
    end

    // Shared D register: loads only while the owner still asserts its request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q     <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            q_q     <= load_dat;
            valid_q <= 1'b1;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.owner = owner_q;
    assign bus.q     = q_q;
    assign bus.qn    = ~q_q;
    assign bus.valid = valid_q;

endmodule

// File: doc/dff_share_arb.md
# dff_share_arb

Round-robin arbiter that shares one WIDTH-bit D flip-flop register among NREQ requesters. Each granted requester drives its data into the shared register exactly as a plain D-FF would, one load per clock edge. The block sits between several producer blocks and a single storage register, and presents the register's q/qn to the consumer side. A tenure limit bounds how long one requester may hold the register while others wait.

## Interface
Parameters:
- WIDTH, 8, data/register width
- NREQ, 4, number of requesters (≥2)
- TENURE, 3, max consecutive granted cycles while another request is pending (≥1)

Ports:
- clk  input  1  single clock, all state on posedge
- rst  input  1  synchronous, active-low reset
- req  input  NREQ  per-requester request, level
- din  input  NREQ*WIDTH  requester k data at bits [k*WIDTH +: WIDTH]
- gnt  output  NREQ  registered one-hot grant (all-zero when idle)
- owner  output  $clog2(NREQ)  index of current/last grantee
- q  output  WIDTH  shared register contents
- qn  output  WIDTH  ~q, continuous
- valid  output  1  high once q has been loaded since reset

## Operation
- Reset: while rst=0 at a posedge, the block sets state=IDLE, gnt=0, owner=0, ptr=0, cnt=0, q=0, valid=0; qn=all ones. Reset dominates all other inputs.
- ptr: rotation start = owner+1 mod NREQ, updated on every new grant.
- Winner: first k with req[k]=1 searching ptr, ptr+1, … wrapping mod NREQ.
- IDLE: gnt=0, q holds. On an edge with |req: go BUSY, gnt=onehot(winner), owner=winner, cnt=1.
- BUSY (owner o):
  - The load happens on every edge where gnt[o]=1 and req[o]=1: q<=din[o], valid<=1. No load when req[o]=0.
  - req[o]=0: rearbitrate over the other requesters. If any is requesting, grant the winner next cycle (no idle gap) with cnt=1. Otherwise go IDLE, gnt=0.
  - req[o]=1, cnt==TENURE, another req pending: switch to the winner (searched from o+1) with cnt=1.
  - Otherwise stay; cnt increments, saturating at TENURE.
- A sole continuous requester keeps the grant indefinitely. Tenure only yields to pending requests.
- Simultaneous owner drop and new request: the new requester takes part in that same rearbitration.
- Only one requester is ever granted, so q is never written by a non-owner.

## Timing
- Idle request at cycle 0: gnt is visible in cycle 1, the first load happens at the end of cycle 1, and q is visible in cycle 2.
- Steady state: q is din[owner] delayed one cycle.
- Handover: the last load by the old owner and the first load by the new owner fall on consecutive edges.
- qn tracks q combinationally, with zero added latency.
- Reset mid-BUSY takes effect at the next edge. The following arbitration starts from ptr=0.

## Structure
- Package dff_share_pkg holds:
  - the state enum (IDLE, BUSY);
  - the width helper constants (owner width, cnt width = $clog2(TENURE+1));
  - the default parameter values.
- One sub-module, dff_rr_pick: combinational rotating priority picker with inputs req and ptr, and outputs any and winner index.
- The top module contains the FSM, the tenure counter and the shared register.

## Test plan
All scenarios use NREQ=4, WIDTH=8, TENURE=3.
1. Reset: rst=0 for 2 cycles with req=4'b1111 → gnt=0, q=8'h00, qn=8'hFF, valid=0, owner=0.
2. Single request: from IDLE, req=4'b0001 and din0=8'hA5 → gnt=0001 in the next cycle; q=8'hA5, qn=8'h5A and valid=1 in the cycle after.
3. Rotation: req=4'b1111 held → gnt is 0001×3, 0010×3, 0100×3, 1000×3, then 0001 again. At each grant, q equals the grantee's din one cycle later.
4. Early release: owner 0 drops req while req[2]=1 → gnt=0100 in the next cycle with no idle gap. q does not change on the edge where req[0]=0.
5. Mid-op reset: rst=0 for one cycle during BUSY, then req=4'b1010 → gnt=0 and q=0 after reset; next grant is 0010.
6. Solo requester: req=4'b0100 for 10 cycles with changing din2 → gnt stays 0100 and q follows din2 one cycle late. Dropping req → IDLE and gnt=0, q holds its last value.
